// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Build option: define FETCH_TRACE_EN to enable the fetch/redirect trace in fetch_unit.
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WAIT  = 2'd1,
    F_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {inst, PC_plus_4} pair that the
// output register could not take because downstream was stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [INST_W-1:0] load_inst,
  input  logic [31:0]       load_pc4,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc4
);

  // Load wins over unload: an entry can move out and a new one in on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc4   <= load_pc4;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem req/ack sequencing, skid-buffered output.
// Build option: FETCH_TRACE_EN prints every ack (kept/discarded) and every redirect target.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       PC_plus_4,
  output fetch_state_t      dbg_state
);

  // Handshakes: imem_req stays high with imem_addr frozen until the cycle imem_ack
  // is high, which completes the read; the output pair moves on inst_valid && !stall.
  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       redirect_tgt;
  logic [31:0]       fetch_pc4;
  logic              accept;
  logic              ack_keep;
  logic              take_mem;
  logic              skid_load;
  logic              skid_unload;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [31:0]       skid_pc4;

  assign redirect_tgt = word_align(redirect_pc);
  assign fetch_pc4    = addr_q + 32'd4;
  assign accept       = inst_valid && !stall;
  assign ack_keep     = (state_q == F_WAIT) && imem_ack && !redirect;
  assign skid_unload  = accept && skid_valid;
  // Memory data goes straight out only when nothing older is queued ahead of it.
  assign take_mem     = ack_keep && (!inst_valid || accept) && !skid_valid;
  assign skid_load    = ack_keep && !take_mem;

  assign imem_req  = (state_q != F_IDLE);
  assign imem_addr = addr_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      F_IDLE: begin
        if (!redirect && (!skid_valid || skid_unload)) begin
          state_d = F_WAIT;
          addr_d  = pc_q;
        end
      end
      F_WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            addr_d = redirect_tgt;
          end else begin
            pc_d = pc_q + 32'd4;
            if (skid_load) state_d = F_IDLE;
            else           addr_d  = pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = F_DRAIN;
        end
      end
      F_DRAIN: begin
        // The stale read must complete before the new address may be presented.
        if (imem_ack) begin
          state_d = F_WAIT;
          addr_d  = redirect ? redirect_tgt : pc_q;
        end
      end
      default: state_d = F_IDLE;
    endcase
    if (redirect) pc_d = redirect_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      PC_plus_4  <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
    end else if (skid_unload) begin
      inst_valid <= 1'b1;
      inst       <= skid_inst;
      PC_plus_4  <= skid_pc4;
    end else if (take_mem) begin
      inst_valid <= 1'b1;
      inst       <= imem_rdata;
      PC_plus_4  <= fetch_pc4;
    end else if (accept) begin
      inst_valid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .unload    (skid_unload),
    .flush     (redirect),
    .load_inst (imem_rdata),
    .load_pc4  (fetch_pc4),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .pc4       (skid_pc4)
  );

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && imem_req && imem_ack)
      $display("fetch: addr=%h rdata=%h %s", addr_q, imem_rdata,
               ack_keep ? "kept" : "discarded");
    if (rst_n && redirect)
      $display("fetch: redirect target=%h", redirect_tgt);
  end
`else
`endif

endmodule
